// File: rtl/risc16_pkg.sv
// Shared constants and fetch-state encoding for the 16-bit RISC core.
package risc16_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_BUSY = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: a redirect load beats the post-fetch increment; the counter wraps.
module fetch_pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              I_CLK,
    input  logic              I_RESET_N,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_next = pc_reg;
        if (load) begin
            pc_next = target;
        end else if (inc) begin
            pc_next = pc_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs req/ack reads to instruction memory, stalls the sequencer.
// Optional fetch timeout with sticky error flag is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import risc16_pkg::*;
#(
    parameter int                ADDR_W      = risc16_pkg::ADDR_W,
    parameter int                DATA_W      = risc16_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR   = risc16_pkg::NOP_INSTR,
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic              I_CLK,
    input  logic              I_RESET_N,
    input  logic              I_ENFETCH,
    input  logic              I_PC_LOAD,
    input  logic [ADDR_W-1:0] I_PC_TARGET,
    output logic              O_MEM_REQ,
    output logic [ADDR_W-1:0] O_MEM_ADDR,
    input  logic              I_MEM_ACK,
    input  logic [DATA_W-1:0] I_MEM_RDATA,
    output logic [DATA_W-1:0] O_INSTR,
    output logic              O_INSTR_VALID,
    output logic [ADDR_W-1:0] O_PC,
    output logic              O_STALL,
    output logic              O_FETCH_ERR
);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] addr_q_reg;
    logic [DATA_W-1:0] instr_reg;
    logic              instr_valid_reg;
    logic [ADDR_W-1:0] pc;
    logic              mem_req;
    logic              capture;
    logic              abort;

    // Gating with the reset pin drops an in-flight request the moment reset asserts.
    assign mem_req    = I_RESET_N & ((state_reg == FS_BUSY) | I_ENFETCH);
    assign capture    = mem_req & I_MEM_ACK;
    assign O_MEM_REQ  = mem_req;
    assign O_MEM_ADDR = (state_reg == FS_BUSY) ? addr_q_reg : pc;
    assign O_STALL    = mem_req & ~I_MEM_ACK;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .I_CLK     (I_CLK),
        .I_RESET_N (I_RESET_N),
        .load      (I_PC_LOAD),
        .target    (I_PC_TARGET),
        .inc       (capture),
        .pc        (pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            fetch_err_reg;

    // Abort fires on the last allowed wait cycle; an ACK in that same cycle still wins.
    assign abort = (state_reg == FS_BUSY) & ~I_MEM_ACK &
                   (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            to_cnt_reg    <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            if (state_reg == FS_IDLE) begin
                to_cnt_reg <= '0;
            end else if (!I_MEM_ACK && !abort) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
            if (abort) begin
                fetch_err_reg <= 1'b1;
            end else if (capture) begin
                fetch_err_reg <= 1'b0;
            end
        end
    end

    assign O_FETCH_ERR = fetch_err_reg;
`else
    assign abort       = 1'b0;
    assign O_FETCH_ERR = 1'b0;
`endif

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_reg       <= FS_IDLE;
            addr_q_reg      <= RESET_PC;
            instr_reg       <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
        end else begin
            instr_valid_reg <= 1'b0;
            case (state_reg)
                FS_IDLE: begin
                    if (I_ENFETCH) begin
                        if (I_MEM_ACK) begin
                            instr_reg       <= I_MEM_RDATA;
                            instr_valid_reg <= 1'b1;
                        end else begin
                            addr_q_reg <= pc;
                            state_reg  <= FS_BUSY;
                        end
                    end
                end
                FS_BUSY: begin
                    if (I_MEM_ACK) begin
                        instr_reg       <= I_MEM_RDATA;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= FS_IDLE;
                    end else if (abort) begin
                        instr_reg       <= NOP_INSTR;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= FS_IDLE;
                    end
                end
                default: state_reg <= FS_IDLE;
            endcase
        end
    end

    assign O_INSTR       = instr_reg;
    assign O_INSTR_VALID = instr_valid_reg;
    assign O_PC          = pc;

endmodule
